// File: rtl/uart_rx_buffered.sv
// Buffered 8N1 UART receiver: synchronised input, 3-sample mid-bit majority vote,
// first-word-fall-through byte FIFO, sticky framing/overrun flags.
module uart_rx_buffered #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       clear_err,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       rx_done,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int H     = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(H);
  localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(H + 1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  logic             rx_meta_reg, rxs_reg;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       idx_reg, idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic [1:0]       samp_reg, samp_next;
  logic             maj, push, pop, set_fe, set_ov;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             rx_done_reg, frame_err_reg, overrun_reg;

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rxs_reg     <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rxs_reg     <= rx_meta_reg;
    end
  end

  // Third sample is the live rxs at the decision count.
  assign maj = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rxs_reg) | (samp_reg[1] & rxs_reg);

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      samp_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      samp_reg  <= samp_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    samp_next  = samp_reg;
    push       = 1'b0;
    set_fe     = 1'b0;
    set_ov     = 1'b0;
    if (cnt_reg == CNT_S0) samp_next[0] = rxs_reg;
    if (cnt_reg == CNT_S1) samp_next[1] = rxs_reg;
    case (state_reg)
      IDLE: begin
        // The detecting cycle is count 0 of the start bit.
        if (!rxs_reg) begin
          state_next = START;
          cnt_next   = CNT_W'(1);
        end else begin
          cnt_next = '0;
        end
      end
      START: begin
        if (cnt_reg == CNT_DEC && maj) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = DATA;
          idx_next   = '0;
        end
      end
      DATA: begin
        if (cnt_reg == CNT_DEC) shift_next[idx_reg] = maj;
        if (cnt_reg == CNT_LAST) begin
          if (idx_reg == 3'd7) state_next = STOP;
          else                 idx_next   = idx_reg + 3'd1;
        end
      end
      STOP: begin
        if (cnt_reg == CNT_DEC) begin
          cnt_next = '0;
          if (maj) begin
            state_next = IDLE;
            if (!full || rd_en) push   = 1'b1;
            else                set_ov = 1'b1;
          end else begin
            state_next = BREAK;
            set_fe     = 1'b1;
          end
        end
      end
      BREAK: begin
        cnt_next = '0;
        if (rxs_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // When full, a push is only issued alongside rd_en, so pop frees the slot.
  assign pop = rd_en & ~empty;

  always_ff @(posedge CLOCK_50) begin
    if (push) mem[wr_ptr_reg] <= shift_reg;
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      rx_done_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      rx_done_reg   <= push;
      frame_err_reg <= set_fe | (frame_err_reg & ~clear_err);
      overrun_reg   <= set_ov | (overrun_reg & ~clear_err);
    end
  end

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_FULL);
  assign rd_data   = empty ? 8'h00 : mem[rd_ptr_reg];
  assign rx_done   = rx_done_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed/randomised bench for uart_rx_buffered against a queue-based model of
// the received byte stream and sticky flags.
`timescale 1ns/1ps
module tb_uart_rx_buffered;
  localparam int CPB   = 16;
  localparam int DEPTH = 8;
  localparam int H     = CPB / 2;
  // Cycles from the frame's launch edge to the edge that writes the FIFO.
  localparam int PUSH_EDGE = 2 + 9 * CPB + H + 2;
  localparam realtime BIT = 160.0;

  logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, rd_en = 1'b0, clear_err = 1'b0;
  logic [7:0] rd_data;
  logic       empty, full, rx_done, frame_err, overrun;

  uart_rx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLOCK_50(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .clear_err(clear_err),
    .rd_data(rd_data), .empty(empty), .full(full), .rx_done(rx_done),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0, pass_cnt = 0, fail_cnt = 0;
  int done_cnt = 0, exp_done = 0;
  logic [7:0] model_q[$];
  logic exp_fe = 1'b0, exp_ov = 1'b0;

  always @(negedge clk) if (rx_done === 1'b1) done_cnt++;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model of one received frame: good bytes queue up, a full queue drops them.
  task automatic model_frame(input logic [7:0] d, input logic stop, input logic popping);
    if (!stop) exp_fe = 1'b1;
    else if (model_q.size() < DEPTH || popping) begin
      if (popping && model_q.size() > 0) void'(model_q.pop_front());
      model_q.push_back(d);
      exp_done++;
    end else exp_ov = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input realtime bp, input realtime extra);
    rx = 1'b0;
    #(bp);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bp);
    end
    rx = stop;
    #(bp);
    #(extra);
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sync_send(input logic [7:0] d, input logic stop);
    @(posedge clk);
    #1;
    send(d, stop, BIT, 0.0);
    model_frame(d, stop, 1'b0);
  endtask

  task automatic check_state(input string tag);
    logic [7:0] exp_head;
    exp_head = (model_q.size() > 0) ? model_q[0] : 8'h00;
    @(negedge clk);
    check({tag, "_empty"}, empty, model_q.size() == 0);
    check({tag, "_full"}, full, model_q.size() == DEPTH);
    check({tag, "_rd_data"}, rd_data, exp_head);
    check({tag, "_frame_err"}, frame_err, exp_fe);
    check({tag, "_overrun"}, overrun, exp_ov);
    check({tag, "_rx_done_count"}, done_cnt, exp_done);
  endtask

  task automatic pop_check(input string tag);
    @(negedge clk);
    check(tag, rd_data, model_q[0]);
    @(posedge clk);
    #1 rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    void'(model_q.pop_front());
  endtask

  task automatic clear_flags();
    @(posedge clk);
    #1 clear_err = 1'b1;
    @(posedge clk);
    #1 clear_err = 1'b0;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic       s;
    idle(3);
    rst = 1'b0;
    check_state("reset");

    // Single byte, then pop back to empty.
    sync_send(8'hA5, 1'b1);
    idle(2);
    check_state("single");
    pop_check("single_pop");
    check_state("single_drained");

    // Nine frames with no gap: eight fill the FIFO, the ninth overruns.
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      d = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : (i == 2) ? 8'h01 : 8'($urandom);
      send(d, 1'b1, BIT, 0.0);
      model_frame(d, 1'b1, 1'b0);
      if (i == 7) check("b2b_full_after_8", full, 1'b1);
    end
    idle(2);
    check_state("b2b");
    while (model_q.size() > 0) pop_check("b2b_pop");
    check_state("b2b_drained");
    clear_flags();
    check_state("b2b_cleared");

    // Start glitch of three cycles is rejected.
    @(posedge clk);
    #1 rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(2 * CPB);
    check_state("glitch");
    sync_send(8'h3C, 1'b1);
    idle(2);
    check_state("after_glitch");
    pop_check("after_glitch_pop");

    // Framing error followed by a 40-bit break.
    @(posedge clk);
    #1;
    send(8'h55, 1'b0, BIT, 40 * BIT);
    model_frame(8'h55, 1'b0, 1'b0);
    idle(2);
    check_state("break");
    sync_send(8'h81, 1'b1);
    idle(2);
    check_state("after_break");
    pop_check("after_break_pop");
    clear_flags();
    check_state("fe_cleared");

    // clear_err in the very cycle the next frame error is raised.
    fork
      sync_send(8'h55, 1'b0);
      begin
        @(posedge clk);
        repeat (PUSH_EDGE - 1) @(posedge clk);
        #1 clear_err = 1'b1;
        @(posedge clk);
        #1 clear_err = 1'b0;
      end
    join
    idle(2);
    check_state("fe_beats_clear");

    // Full FIFO, pop on the push cycle of 0x7E.
    for (int i = 0; i < DEPTH; i++) sync_send(8'($urandom), 1'b1);
    idle(2);
    check_state("refill");
    fork
      begin
        @(posedge clk);
        #1;
        send(8'h7E, 1'b1, BIT, 0.0);
      end
      begin
        @(posedge clk);
        repeat (PUSH_EDGE - 1) @(posedge clk);
        #1 rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
      end
    join
    model_frame(8'h7E, 1'b1, 1'b1);
    idle(2);
    check_state("push_pop_full");
    while (model_q.size() > 1) pop_check("push_pop_drain");
    check("push_pop_last", rd_data, 8'h7E);
    pop_check("push_pop_last_pop");

    // Reset during data bit 4 loses the FIFO and the flags.
    sync_send(8'($urandom), 1'b1);
    @(posedge clk);
    #1 rx = 1'b0;
    #(BIT);
    rx = 1'b1;
    #(4.5 * BIT);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(1);
    rst = 1'b0;
    model_q.delete();
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    check_state("mid_frame_reset");
    idle(10 * CPB);
    sync_send(8'hC3, 1'b1);
    idle(2);
    check_state("after_reset");
    pop_check("after_reset_pop");

    // Bit period 4% slow then 4% fast.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      send(8'hC3, 1'b1, (k == 0) ? BIT * 1.04 : BIT * 0.96, 0.0);
      model_frame(8'hC3, 1'b1, 1'b0);
      idle(CPB);
      check_state((k == 0) ? "slow" : "fast");
      pop_check((k == 0) ? "slow_pop" : "fast_pop");
    end

    // Random bytes, occasional bad stop bits, random draining.
    for (int i = 0; i < 14; i++) begin
      d = 8'($urandom);
      s = ($urandom_range(5) != 0);
      sync_send(d, s);
      idle(2);
      if (model_q.size() > 0 && $urandom_range(2) == 0) pop_check("rand_pop");
    end
    idle(2);
    check_state("random");
    while (model_q.size() > 0) pop_check("rand_drain");
    check_state("random_drained");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
